pagerank_row_engine: RTL
========================

Name: pagerank_row_engine

Overview:
- Compute stage directly downstream of the PageRank scheduler. The scheduler reads the rank vector R and the link matrix G from test memory, then streams them in.
- This block holds R in a local register file and computes one fixed-point dot product per G row: R'[i] = sum over j of G[i][j]*R[j].
- Each result goes back to the scheduler on a val/rdy port; the scheduler writes it to memory.
- One full pass is nnodes rows. After a pass the block returns to loading R for the next iteration.

Parameters:
- nbits, 32: word width of R, G and result data.
- nnodes, 8: vector length and matrix dimension; power of two, 2..256.
- frac, 16: fractional bits of the fixed-point format (Q(nbits-frac).frac); must be less than nbits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- r_in_val  in  1  R element valid.
- r_in_rdy  out  1  R element accepted when val&&rdy.
- r_in_data  in  nbits  R[j]; elements arrive in order j=0..nnodes-1.
- g_in_val  in  1  G element valid.
- g_in_rdy  out  1  G element accepted when val&&rdy.
- g_in_data  in  nbits  G[i][j]; row-major order.
- out_val  out  1  row result valid.
- out_rdy  in  1  downstream ready.
- out_row  out  $clog2(nnodes)  row index i of the result.
- out_data  out  nbits  R'[i].
- done  out  1  one-cycle pulse at end of a full pass.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=LOAD; j_cnt=0, row_cnt=0, acc=0; R regfile cleared to 0.
  - Outputs: r_in_rdy=1, g_in_rdy=0, out_val=0, out_row=0, out_data=0, done=0.
  - Reset mid-operation abandons the pass; a partial acc is never emitted.
- States: LOAD, RUN, EMIT, DONE.
- LOAD:
  - r_in_rdy=1; all other handshake outputs 0.
  - On r_in handshake: rreg[j_cnt]<=r_in_data; j_cnt++.
  - Handshake when j_cnt==nnodes-1: j_cnt<=0, go to RUN.
- RUN:
  - g_in_rdy=1.
  - On g_in handshake: prod = signed(g_in_data)*signed(rreg[j_cnt]), full 2*nbits wide.
  - Arithmetic shift right by frac, truncate to nbits, then acc<=acc+term with two's-complement wrap (no saturation); j_cnt++.
  - Handshake when j_cnt==nnodes-1: acc takes the final term, j_cnt<=0, go to EMIT.
  - No g_in handshake means no state change; stalls of any length are allowed.
- EMIT:
  - out_val=1, out_data=acc, out_row=row_cnt; g_in_rdy=0.
  - out_data and out_row hold stable while out_rdy=0.
  - On handshake: acc<=0. If row_cnt==nnodes-1, row_cnt<=0 and go to DONE; else row_cnt++ and go to RUN.
- DONE:
  - done=1 for exactly one cycle; then LOAD, with r_in_rdy=1 the following cycle.
- Latency:
  - The first out_val comes one cycle after the last G element of a row is accepted.
  - Minimum throughput is nnodes+1 cycles per row; the pass adds nnodes load cycles and 1 DONE cycle.
- Port exclusivity: r_in_rdy and g_in_rdy are never both 1. Inputs offered in the wrong state are ignored; rdy stays 0.
- The R regfile is read only in RUN and written only in LOAD, so no bypass is needed.
- Registered outputs: out_val, out_data, out_row, done.

Test Plan:
- Unit pass (nnodes=8, frac=16): all R=0x00010000, all G=0x00002000 -> 8 results, each out_data=0x00010000, out_row 0..7, then one done pulse.
- Identity G: R=[1..8]<<16, G[i][i]=0x00010000, others 0 -> out_data[i]=(i+1)<<16; done asserted exactly once.
- Backpressure and stalls: random g_in_val gaps and out_rdy held low 5 cycles per row -> results unchanged; out_data stable while stalled; g_in_rdy=0 throughout EMIT.
- Negative and wrap: G=0xFFFF0000 (-1.0), R=0x7FFF0000 -> out_data=two's-complement wrapped sum 0x00080000 per row.
- Reset mid-RUN at row 3, j=5: assert reset=0 -> out_val=0 immediately and state LOAD. A new full pass then gives correct results starting at out_row=0.
- Back-to-back passes: second R load starts the cycle after done -> no stale acc; rows 0..7 correct for the new R.

Source files
------------

// File: rtl/pagerank_row_engine.sv
// PageRank row engine: holds the rank vector R locally and produces one
// fixed-point dot product per streamed G row, returned on a val/rdy port.
module pagerank_row_engine #(
    parameter int nbits  = 32,
    parameter int nnodes = 8,
    parameter int frac   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      r_in_val,
    output logic                      r_in_rdy,
    input  logic [nbits-1:0]          r_in_data,
    input  logic                      g_in_val,
    output logic                      g_in_rdy,
    input  logic [nbits-1:0]          g_in_data,
    output logic                      out_val,
    input  logic                      out_rdy,
    output logic [$clog2(nnodes)-1:0] out_row,
    output logic [nbits-1:0]          out_data,
    output logic                      done
);

    localparam int idx_w = $clog2(nnodes);
    localparam logic [idx_w-1:0] last_idx = idx_w'(nnodes - 1);

    localparam logic [1:0] st_load = 2'd0;
    localparam logic [1:0] st_run  = 2'd1;
    localparam logic [1:0] st_emit = 2'd2;
    localparam logic [1:0] st_done = 2'd3;

    // Signed full-width product, arithmetic shift by frac, truncated back to nbits.
    function automatic logic [nbits-1:0] fx_term(input logic [nbits-1:0] g,
                                                 input logic [nbits-1:0] r);
        logic signed [2*nbits-1:0] g_ext;
        logic signed [2*nbits-1:0] r_ext;
        logic signed [2*nbits-1:0] prod;
        logic signed [2*nbits-1:0] shifted;
        g_ext   = $signed({{nbits{g[nbits-1]}}, g});
        r_ext   = $signed({{nbits{r[nbits-1]}}, r});
        prod    = g_ext * r_ext;
        shifted = prod >>> frac;
        return shifted[nbits-1:0];
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [idx_w-1:0] j_cnt_r;
    logic [idx_w-1:0] row_cnt_r;
    logic [nbits-1:0] acc_r;
    logic [nbits-1:0] rreg_r [nnodes];

    logic             out_val_r;
    logic [idx_w-1:0] out_row_r;
    logic [nbits-1:0] out_data_r;
    logic             done_r;

    logic             r_rdy_s;
    logic             g_rdy_s;
    logic             r_fire_s;
    logic             g_fire_s;
    logic             o_fire_s;
    logic             j_last_s;
    logic             row_last_s;
    logic [nbits-1:0] term_s;
    logic [nbits-1:0] acc_sum_s;

    assign j_last_s   = (j_cnt_r == last_idx);
    assign row_last_s = (row_cnt_r == last_idx);
    assign term_s     = fx_term(g_in_data, rreg_r[j_cnt_r]);
    assign acc_sum_s  = acc_r + term_s;

    // Handshake decode and next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        r_rdy_s     = 1'b0;
        g_rdy_s     = 1'b0;
        r_fire_s    = 1'b0;
        g_fire_s    = 1'b0;
        o_fire_s    = 1'b0;
        case (state_r)
            st_load: begin
                r_rdy_s  = 1'b1;
                r_fire_s = r_in_val;
                if (r_fire_s && j_last_s) begin
                    state_nxt_s = st_run;
                end else begin
                    state_nxt_s = st_load;
                end
            end
            st_run: begin
                g_rdy_s  = 1'b1;
                g_fire_s = g_in_val;
                if (g_fire_s && j_last_s) begin
                    state_nxt_s = st_emit;
                end else begin
                    state_nxt_s = st_run;
                end
            end
            st_emit: begin
                o_fire_s = out_rdy;
                if (o_fire_s) begin
                    state_nxt_s = row_last_s ? st_done : st_run;
                end else begin
                    state_nxt_s = st_emit;
                end
            end
            st_done: begin
                state_nxt_s = st_load;
            end
            default: begin
                state_nxt_s = st_load;
            end
        endcase
    end

    assign r_in_rdy = r_rdy_s;
    assign g_in_rdy = g_rdy_s;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= st_load;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Element index shared by the R load and the G row walk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            j_cnt_r <= '0;
        end else if (r_fire_s || g_fire_s) begin
            j_cnt_r <= j_last_s ? '0 : j_cnt_r + idx_w'(1);
        end else begin
            j_cnt_r <= j_cnt_r;
        end
    end

    // Row index advances only when a result leaves the block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_cnt_r <= '0;
        end else if (o_fire_s) begin
            row_cnt_r <= row_last_s ? '0 : row_cnt_r + idx_w'(1);
        end else begin
            row_cnt_r <= row_cnt_r;
        end
    end

    // Accumulator: wraps on overflow, cleared once the row result is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_r <= '0;
        end else if (g_fire_s) begin
            acc_r <= acc_sum_s;
        end else if (o_fire_s) begin
            acc_r <= '0;
        end else begin
            acc_r <= acc_r;
        end
    end

    // R register file, written only while loading.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < nnodes; k++) begin
                rreg_r[k] <= '0;
            end
        end else if (r_fire_s) begin
            rreg_r[j_cnt_r] <= r_in_data;
        end else begin
            rreg_r <= rreg_r;
        end
    end

    // Result port: captured with the final term so it is valid the next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_val_r  <= 1'b0;
            out_row_r  <= '0;
            out_data_r <= '0;
        end else if (g_fire_s && j_last_s) begin
            out_val_r  <= 1'b1;
            out_row_r  <= row_cnt_r;
            out_data_r <= acc_sum_s;
        end else if (o_fire_s) begin
            out_val_r  <= 1'b0;
            out_row_r  <= out_row_r;
            out_data_r <= out_data_r;
        end else begin
            out_val_r  <= out_val_r;
            out_row_r  <= out_row_r;
            out_data_r <= out_data_r;
        end
    end

    // End-of-pass pulse, high during the single DONE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_r <= 1'b0;
        end else begin
            done_r <= o_fire_s && row_last_s;
        end
    end

    assign out_val  = out_val_r;
    assign out_row  = out_row_r;
    assign out_data = out_data_r;
    assign done     = done_r;

endmodule
